// File: rtl/qed_issue_scheduler.sv
// Issue scheduler for QED self-consistency checking: interleaves originals, queued duplicates and NOPs.
// Optional macro QED_MAX_LEAD_EN adds MAX_LEAD, a cap on how far originals may run ahead of duplicates.
module qed_issue_scheduler #(
    parameter int          DEPTH        = 8,
    parameter int          CNT_W        = 8,
    parameter int          DRAIN_CYCLES = 5,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013
`ifdef QED_MAX_LEAD_EN
    , parameter int        MAX_LEAD     = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_instr,
    input  logic [31:0]      fetch_dup_instr,
    output logic             fetch_ready,
    input  logic             exec_dup,
    input  logic             stall,
    output logic [31:0]      issue_instr,
    output logic             issue_is_dup,
    output logic [CNT_W-1:0] qed_num_orig,
    output logic [CNT_W-1:0] qed_num_dup,
    output logic             qed_check_valid,
    output logic             sif_commit,
    output logic             sif_commit_pulsed,
    output logic [1:0]       sif_state,
    output logic             cnt_overflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_CHECK = 2'd3
    } sif_state_t;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [DRN_W-1:0] drain;
    sif_state_t       state;
    logic             empty;
    logic             full;
    logic             at_limit;
    logic             do_pop;
    logic             do_push;
    logic             counts_equal;

    assign empty = (head == tail);
    assign full  = (head[IDX_W] != tail[IDX_W]) && (head[IDX_W-1:0] == tail[IDX_W-1:0]);

`ifdef QED_MAX_LEAD_EN
    logic [PTR_W-1:0] occupancy;
    assign occupancy = tail - head;
    assign at_limit  = full || (occupancy >= PTR_W'(MAX_LEAD));
`else
    assign at_limit  = full;
`endif

    // fetch side is valid/ready: an original transfers on a cycle where fetch_valid and
    // fetch_ready are both high; fetch_ready never depends on fetch_instr and is low in stall/reset.
    assign do_pop      = !rst && !stall && (at_limit || (exec_dup && !empty));
    assign do_push     = !rst && !stall && !do_pop && fetch_valid;
    assign fetch_ready = do_push;

    assign counts_equal    = (qed_num_orig == qed_num_dup);
    assign qed_check_valid = counts_equal && (qed_num_orig != '0) && empty &&
                             (drain == '0) && !cnt_overflow;
    assign sif_commit      = (state == S_CHECK);
    assign sif_state       = state;

    // Queue storage needs no reset: only entries between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail[IDX_W-1:0]] <= fetch_dup_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head              <= '0;
            tail              <= '0;
            drain             <= '0;
            qed_num_orig      <= '0;
            qed_num_dup       <= '0;
            cnt_overflow      <= 1'b0;
            issue_instr       <= NOP_INSTR;
            issue_is_dup      <= 1'b0;
            sif_commit_pulsed <= 1'b0;
            state             <= S_IDLE;
        end else begin
            sif_commit_pulsed <= 1'b0;

            if (do_pop) begin
                issue_instr  <= mem[head[IDX_W-1:0]];
                issue_is_dup <= 1'b1;
                head         <= head + PTR_W'(1);
                drain        <= DRN_W'(DRAIN_CYCLES);
                if (qed_num_dup == CNT_MAX) cnt_overflow <= 1'b1;
                else                        qed_num_dup  <= qed_num_dup + CNT_W'(1);
            end else if (do_push) begin
                issue_instr  <= fetch_instr;
                issue_is_dup <= 1'b0;
                tail         <= tail + PTR_W'(1);
                drain        <= DRN_W'(DRAIN_CYCLES);
                if (qed_num_orig == CNT_MAX) cnt_overflow <= 1'b1;
                else                         qed_num_orig <= qed_num_orig + CNT_W'(1);
            end else begin
                // A stall holds the last issued instruction; otherwise a bubble goes out.
                if (!stall) begin
                    issue_instr  <= NOP_INSTR;
                    issue_is_dup <= 1'b0;
                end
                if (drain != '0) drain <= drain - DRN_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (do_push) state <= S_RUN;
                end
                S_RUN: begin
                    if (!do_push && empty && counts_equal) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (do_push) begin
                        state <= S_RUN;
                    end else if (qed_check_valid) begin
                        state             <= S_CHECK;
                        sif_commit_pulsed <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (do_push) state <= S_RUN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qed_issue_scheduler.sv
// Directed bench for qed_issue_scheduler: a default instance plus a CNT_W=2 instance
// sharing the same stimulus for the counter saturation scenario.
module tb_qed_issue_scheduler;

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] O_BASE = 32'h10000000;
    localparam logic [31:0] D_BASE = 32'h20000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_instr = '0;
    logic [31:0] fetch_dup_instr = '0;
    logic        exec_dup = 1'b0;
    logic        stall = 1'b0;

    logic        fetch_ready, issue_is_dup, qed_check_valid, sif_commit, sif_commit_pulsed, cnt_overflow;
    logic [31:0] issue_instr;
    logic [7:0]  qed_num_orig, qed_num_dup;
    logic [1:0]  sif_state;

    logic        s_fetch_ready, s_issue_is_dup, s_check_valid, s_commit, s_pulsed, s_overflow;
    logic [31:0] s_issue_instr;
    logic [1:0]  s_num_orig, s_num_dup, s_state;

    int n_checks = 0;
    int n_errors = 0;

    qed_issue_scheduler dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_dup_instr(fetch_dup_instr), .fetch_ready(fetch_ready), .exec_dup(exec_dup),
        .stall(stall), .issue_instr(issue_instr), .issue_is_dup(issue_is_dup),
        .qed_num_orig(qed_num_orig), .qed_num_dup(qed_num_dup), .qed_check_valid(qed_check_valid),
        .sif_commit(sif_commit), .sif_commit_pulsed(sif_commit_pulsed), .sif_state(sif_state),
        .cnt_overflow(cnt_overflow)
    );

    qed_issue_scheduler #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_dup_instr(fetch_dup_instr), .fetch_ready(s_fetch_ready), .exec_dup(exec_dup),
        .stall(stall), .issue_instr(s_issue_instr), .issue_is_dup(s_issue_is_dup),
        .qed_num_orig(s_num_orig), .qed_num_dup(s_num_dup), .qed_check_valid(s_check_valid),
        .sif_commit(s_commit), .sif_commit_pulsed(s_pulsed), .sif_state(s_state),
        .cnt_overflow(s_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        fetch_valid = 1'b0;
        exec_dup    = 1'b0;
        stall       = 1'b0;
    endtask

    task automatic set_fetch(input int n);
        fetch_valid     = 1'b1;
        fetch_instr     = O_BASE + 32'(n);
        fetch_dup_instr = D_BASE + 32'(n);
    endtask

    task automatic do_reset();
        go_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_check_valid(input string tag);
        int n;
        n = 0;
        while (!qed_check_valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and basic O0,O1,O2,D0,D1,D2 ordering
        do_reset();
        check("rst_instr", issue_instr, NOP);
        check("rst_is_dup", 32'(issue_is_dup), 32'd0);
        check("rst_orig", 32'(qed_num_orig), 32'd0);
        check("rst_dup", 32'(qed_num_dup), 32'd0);
        check("rst_state", 32'(sif_state), 32'd0);
        check("rst_cv", 32'(qed_check_valid), 32'd0);
        check("rst_commit", 32'(sif_commit), 32'd0);
        check("rst_pulse", 32'(sif_commit_pulsed), 32'd0);
        check("rst_ovf", 32'(cnt_overflow), 32'd0);

        for (int i = 0; i < 3; i++) begin
            set_fetch(i);
            #1 check("orig_ready", 32'(fetch_ready), 32'd1);
            tick();
            check("orig_instr", issue_instr, O_BASE + 32'(i));
            check("orig_is_dup", 32'(issue_is_dup), 32'd0);
        end
        check("orig_count3", 32'(qed_num_orig), 32'd3);
        check("state_run", 32'(sif_state), 32'd1);

        fetch_valid = 1'b0;
        exec_dup    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dup_instr", issue_instr, D_BASE + 32'(i));
            check("dup_is_dup", 32'(issue_is_dup), 32'd1);
        end
        check("dup_count3", 32'(qed_num_dup), 32'd3);
        exec_dup = 1'b0;

        wait_check_valid("drain_latency");
        check("drain_state", 32'(sif_state), 32'd2);
        check("pulse_early", 32'(sif_commit_pulsed), 32'd0);
        tick();
        check("check_state", 32'(sif_state), 32'd3);
        check("pulse_high", 32'(sif_commit_pulsed), 32'd1);
        check("commit_high", 32'(sif_commit), 32'd1);
        tick();
        check("pulse_once", 32'(sif_commit_pulsed), 32'd0);
        check("check_hold", 32'(sif_state), 32'd3);

        // Original issued while in CHECK
        set_fetch(3);
        tick();
        check("rerun_state", 32'(sif_state), 32'd1);
        check("rerun_commit", 32'(sif_commit), 32'd0);
        check("rerun_cv", 32'(qed_check_valid), 32'd0);
        check("rerun_orig", 32'(qed_num_orig), 32'd4);
        fetch_valid = 1'b0;
        exec_dup    = 1'b1;
        tick();
        check("rerun_dup", issue_instr, D_BASE + 32'd3);
        exec_dup = 1'b0;

        // Fill to DEPTH, forced duplicate, then stall hold and in-order drain
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_fetch(i);
            #1 check("fill_ready", 32'(fetch_ready), 32'd1);
            tick();
            check("fill_instr", issue_instr, O_BASE + 32'(i));
        end
        set_fetch(8);
        #1 check("full_ready", 32'(fetch_ready), 32'd0);
        tick();
        check("forced_dup", issue_instr, D_BASE);
        check("forced_is_dup", 32'(issue_is_dup), 32'd1);
        check("full_orig", 32'(qed_num_orig), 32'd8);
        check("full_dup", 32'(qed_num_dup), 32'd1);
        #1 check("refill_ready", 32'(fetch_ready), 32'd1);
        tick();
        check("refill_instr", issue_instr, O_BASE + 32'd8);
        check("refill_orig", 32'(qed_num_orig), 32'd9);

        stall = 1'b1;
        set_fetch(9);
        for (int i = 0; i < 4; i++) begin
            #1 check("stall_ready", 32'(fetch_ready), 32'd0);
            tick();
            check("stall_instr", issue_instr, O_BASE + 32'd8);
            check("stall_orig", 32'(qed_num_orig), 32'd9);
            check("stall_dup", 32'(qed_num_dup), 32'd1);
        end
        stall       = 1'b0;
        fetch_valid = 1'b0;
        exec_dup    = 1'b1;
        for (int i = 1; i < 9; i++) begin
            tick();
            check("resume_dup", issue_instr, D_BASE + 32'(i));
        end
        check("resume_count", 32'(qed_num_dup), 32'd9);
        tick();
        check("empty_nop", issue_instr, NOP);
        check("empty_is_dup", 32'(issue_is_dup), 32'd0);
        exec_dup = 1'b0;

        // Reset mid-operation with 5 entries queued
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_fetch(i);
            tick();
        end
        fetch_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst_instr", issue_instr, NOP);
        check("mid_rst_orig", 32'(qed_num_orig), 32'd0);
        check("mid_rst_dup", 32'(qed_num_dup), 32'd0);
        check("mid_rst_state", 32'(sif_state), 32'd0);
        rst      = 1'b0;
        exec_dup = 1'b1;
        tick();
        check("mid_rst_discard", issue_instr, NOP);
        check("mid_rst_no_dup", 32'(qed_num_dup), 32'd0);
        exec_dup = 1'b0;

        // Saturation on the CNT_W=2 instance
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_fetch(i);
            tick();
        end
        fetch_valid = 1'b0;
        exec_dup    = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        exec_dup = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("sat_cv_before", 32'(s_check_valid), 32'd1);
        check("sat_ovf_before", 32'(s_overflow), 32'd0);
        set_fetch(3);
        tick();
        fetch_valid = 1'b0;
        check("sat_ovf", 32'(s_overflow), 32'd1);
        check("sat_orig_held", 32'(s_num_orig), 32'd3);
        exec_dup = 1'b1;
        tick();
        exec_dup = 1'b0;
        check("sat_dup_instr", s_issue_instr, D_BASE + 32'd3);
        for (int i = 0; i < 8; i++) tick();
        check("sat_cv_blocked", 32'(s_check_valid), 32'd0);
        check("sat_ovf_sticky", 32'(s_overflow), 32'd1);
        check("wide_cv", 32'(qed_check_valid), 32'd1);
        check("wide_counts", 32'(qed_num_dup), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/qed_issue_scheduler.md
Name: qed_issue_scheduler

Overview:
- Sits between the fetch stage and the core decode input in the QED-instrumented design.
- Chooses each cycle whether to issue an original instruction from fetch, a queued duplicate (pre-transformed upstream: regs +16, mem offset +16), or a NOP bubble.
- Tracks original and duplicate issue counts and drives the commit FSM.
- Produces qed_check_valid, sif_commit and sif_commit_pulsed for the formal consistency properties.

Parameters:
- DEPTH, 8, duplicate queue entries (power of 2, >=2)
- CNT_W, 8, width of qed_num_orig / qed_num_dup
- DRAIN_CYCLES, 5, cycles after the last issue before the pipeline is considered retired
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_valid  in  1  original instruction available
- fetch_instr  in  32  original instruction
- fetch_dup_instr  in  32  transformed duplicate of fetch_instr
- fetch_ready  out  1  original accepted this cycle
- exec_dup  in  1  free (symbolic) choice: prefer duplicate issue
- stall  in  1  core cannot accept an instruction
- issue_instr  out  32  instruction to decode
- issue_is_dup  out  1  issue_instr is a duplicate
- qed_num_orig  out  CNT_W  originals issued since reset
- qed_num_dup  out  CNT_W  duplicates issued since reset
- qed_check_valid  out  1  counts equal, queue empty, pipeline drained
- sif_commit  out  1  FSM in CHECK
- sif_commit_pulsed  out  1  one-cycle pulse on entry to CHECK (T_C)
- sif_state  out  2  FSM state
- cnt_overflow  out  1  sticky: a counter saturated

Behaviour:
- Reset: queue empty (head=tail=0), counters 0, sif_state IDLE(0), issue_instr=NOP_INSTR, all 1-bit outputs 0.
- Issue decision is registered; issue_instr valid 1 cycle after the decision. Priority when !stall:
  1. Queue full, or exec_dup with queue non-empty: pop head, issue the duplicate, issue_is_dup=1, qed_num_dup++.
  2. Else fetch_valid and queue not full: fetch_ready=1, issue fetch_instr, push fetch_dup_instr at tail, qed_num_orig++.
  3. Else issue NOP_INSTR; no counter change.
- stall=1: fetch_ready=0, no push/pop, issue_instr and counters held.
- Single issue slot: a push and a pop never occur in the same cycle.
- Pointers are log2(DEPTH)+1 bits with wrap. full = MSBs differ and indices equal; empty = pointers equal.
- Counters saturate at 2^CNT_W-1. Saturation sets cnt_overflow (sticky until rst). While cnt_overflow=1, qed_check_valid is forced to 0.
- Drain counter: loads DRAIN_CYCLES on every non-NOP issue, decrements to 0 otherwise.
- qed_check_valid = (qed_num_orig==qed_num_dup) && qed_num_orig!=0 && empty && drain==0 && !cnt_overflow. Combinational from registers.
- FSM (sif_state encoding):
  - IDLE(0) -> RUN(1) on the first original issue.
  - RUN -> DRAIN(2) when empty and counts equal.
  - DRAIN -> RUN if a new original issues; DRAIN -> CHECK(3) when qed_check_valid.
  - CHECK -> RUN on the next original issue; otherwise stays in CHECK.
  - sif_commit=1 in CHECK. sif_commit_pulsed=1 only on the cycle after the DRAIN->CHECK transition.
- rst asserted mid-operation clears everything in the next cycle; queued duplicates are discarded.

Optional Feature:
- Macro QED_MAX_LEAD_EN: adds parameter MAX_LEAD (default 4, <=DEPTH).
  - With macro: originals are blocked (fetch_ready=0) when occupancy >= MAX_LEAD; rule 1 then forces a duplicate issue at that occupancy.
  - Without macro: the limit is DEPTH (full) only.

Test Plan:
- Reset then 3 originals with exec_dup=0, then exec_dup=1 for 3 cycles -> issue order O0,O1,O2,D0,D1,D2; counts 3/3; qed_check_valid rises exactly 5 cycles after D2 issue; sif_commit_pulsed high 1 cycle; sif_state=3.
- fetch_valid=1 held, exec_dup=0, DEPTH=8 -> 8 originals, then fetch_ready=0 and forced duplicate on the 9th issue slot; occupancy never exceeds 8.
- stall=1 for 4 cycles mid-stream -> issue_instr, counters and pointers unchanged; resumes with no lost or duplicated entry.
- Originals issued while in CHECK -> next cycle sif_state=RUN, sif_commit=0, qed_check_valid=0.
- CNT_W=2, issue 3 orig + 3 dup, then one more original -> cnt_overflow=1, qed_check_valid stays 0 after the matching duplicate.
- rst asserted with 5 entries queued -> next cycle empty, counts 0, sif_state=0, issue_instr=0x00000013.
